// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the five-stage Y86-64 core: hazard detection, stage-register
// stall/bubble generation, run/pause/step/dead machine state and saturating perf counters.
module pipe_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic [0:3]       m_stat,
   input  logic [0:3]       W_stat,
   input  logic [3:0]       W_icode,
   input  logic             dbg_halt_req,
   input  logic             dbg_step,
   output logic             F_stall,
   output logic             D_stall,
   output logic             E_stall,
   output logic             M_stall,
   output logic             W_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic [0:3]       cpu_stat,
   output logic             halted,
   output logic             paused,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam logic [3:0] IcodeNop    = 4'h1;
   localparam logic [3:0] IcodeMrmovq = 4'h5;
   localparam logic [3:0] IcodeJxx    = 4'h7;
   localparam logic [3:0] IcodeRet    = 4'h9;
   localparam logic [3:0] IcodePopq   = 4'hB;
   localparam logic [3:0] RegNone     = 4'hF;
   localparam logic [0:3] StatAok     = 4'b1000;

   typedef enum logic [1:0] {StRun, StPause, StStep, StDead} state_e;

   state_e           state_q, state_d;
   logic             lu, ret_haz, mp, exc_m, exc_w;
   logic             run_f_stall, run_d_stall, run_d_bubble, run_e_bubble, run_m_bubble;
   logic             cnt_en;
   logic [0:3]       cpu_stat_q;
   logic [CNT_W-1:0] cycle_q, retired_q, stall_q, mispred_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
   endfunction

   // Hazard terms and the standard PIPE control values used in RUN/STEP
   always_comb begin
      lu = ((E_icode == IcodeMrmovq) || (E_icode == IcodePopq)) && (E_dstM != RegNone) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      ret_haz = (D_icode == IcodeRet) || (E_icode == IcodeRet) || (M_icode == IcodeRet);
      mp      = (E_icode == IcodeJxx) && !e_Cnd;
      exc_m   = (m_stat != StatAok);
      exc_w   = (W_stat != StatAok);
      run_f_stall  = lu || ret_haz;
      run_d_stall  = lu;
      // Stall wins over bubble on D
      run_d_bubble = (mp || (!lu && ret_haz)) && !lu;
      run_e_bubble = mp || lu;
      run_m_bubble = exc_m || exc_w;
   end

   // Next state, stage control outputs and counter enable
   always_comb begin
      state_d  = state_q;
      cnt_en   = 1'b0;
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      E_stall  = 1'b0;
      M_stall  = 1'b0;
      W_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      unique case (state_q)
         StRun, StStep: begin
            F_stall  = run_f_stall;
            D_stall  = run_d_stall;
            W_stall  = exc_w;
            D_bubble = run_d_bubble;
            E_bubble = run_e_bubble;
            M_bubble = run_m_bubble;
            cnt_en   = 1'b1;
            if (state_q == StStep) begin
               state_d = StPause;
            end else if (dbg_halt_req) begin
               state_d = StPause;
            end
         end
         StPause: begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            E_stall = 1'b1;
            M_stall = 1'b1;
            W_stall = 1'b1;
            if (!dbg_halt_req) begin
               state_d = StRun;
            end else if (dbg_step) begin
               state_d = StStep;
            end
         end
         StDead: begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            W_stall  = 1'b1;
            M_bubble = 1'b1;
         end
         default: ;
      endcase
      // W exception overrides everything; the entry cycle of DEAD is not counted
      if (exc_w) begin
         state_d = StDead;
         cnt_en  = 1'b0;
      end
      // Flush while reset is held
      if (rst) begin
         F_stall  = 1'b0;
         D_stall  = 1'b0;
         E_stall  = 1'b0;
         M_stall  = 1'b0;
         W_stall  = 1'b0;
         D_bubble = 1'b1;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
      end
   end

   // Machine state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // Status latches the offending W_stat on entry to DEAD, then holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_stat_q <= StatAok;
      end else if (exc_w && (state_q != StDead)) begin
         cpu_stat_q <= W_stat;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q   <= '0;
         retired_q <= '0;
         stall_q   <= '0;
         mispred_q <= '0;
      end else if (cnt_en) begin
         cycle_q   <= sat_inc(cycle_q, 1'b1);
         retired_q <= sat_inc(retired_q, W_icode != IcodeNop);
         stall_q   <= sat_inc(stall_q, run_f_stall);
         mispred_q <= sat_inc(mispred_q, mp);
      end
   end

   assign cpu_stat    = cpu_stat_q;
   assign halted      = (state_q == StDead);
   assign paused      = (state_q == StPause);
   assign cycle_cnt   = cycle_q;
   assign retired_cnt = retired_q;
   assign stall_cnt   = stall_q;
   assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the control rules. Counters are 4 bits wide so saturation is reachable.
module tb_pipe_ctrl;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
   logic          e_Cnd, dbg_halt_req, dbg_step;
   logic [0:3]    m_stat, W_stat;
   logic          F_stall, D_stall, E_stall, M_stall, W_stall;
   logic          D_bubble, E_bubble, M_bubble, halted, paused;
   logic [0:3]    cpu_stat;
   logic [CW-1:0] cycle_cnt, retired_cnt, stall_cnt, mispred_cnt;

   logic [7:0]    ctl;
   logic [15:0]   cnts;
   logic [21:0]   regs;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   typedef enum {MRun, MPause, MStep, MDead} mstate_e;
   mstate_e    m_state;
   logic [0:3] m_cpu;
   logic [3:0] m_cyc, m_ret, m_stl, m_mp;

   pipe_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
      .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
      .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
      .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
      .W_stall(W_stall), .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
      .cpu_stat(cpu_stat), .halted(halted), .paused(paused),
      .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
      .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   assign ctl  = {F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble};
   assign cnts = {cycle_cnt, retired_cnt, stall_cnt, mispred_cnt};
   assign regs = {halted, paused, cpu_stat, cnts};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic set_idle();
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b0;
      m_stat = 4'b1000; W_stat = 4'b1000; dbg_halt_req = 1'b0; dbg_step = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---- reference model ----
   task automatic model_reset();
      m_state = MRun; m_cpu = 4'b1000;
      m_cyc = 0; m_ret = 0; m_stl = 0; m_mp = 0;
   endtask

   function automatic logic [3:0] sat(input logic [3:0] v, input logic inc);
      return (inc && v < 4'd15) ? v + 4'd1 : v;
   endfunction

   function automatic logic [7:0] exp_ctl();
      logic lu, rt, mp, em, ew;
      if (rst) return 8'b00000111;
      if (m_state == MDead) return 8'b11101001;
      if (m_state == MPause) return 8'b11111000;
      lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
      rt = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
      mp = E_icode == 4'h7 && !e_Cnd;
      em = m_stat != 4'b1000;
      ew = W_stat != 4'b1000;
      return {lu | rt, lu, 1'b0, 1'b0, ew, mp | (!lu & rt), mp | lu, em | ew};
   endfunction

   // Advance the model across one clock edge using the current inputs
   task automatic model_clock();
      logic [7:0] c;
      logic       ew;
      c  = exp_ctl();
      ew = W_stat != 4'b1000;
      if ((m_state == MRun || m_state == MStep) && !ew) begin
         m_cyc = sat(m_cyc, 1'b1);
         m_ret = sat(m_ret, W_icode != 4'h1);
         m_stl = sat(m_stl, c[7]);
         m_mp  = sat(m_mp, E_icode == 4'h7 && !e_Cnd);
      end
      if (ew && m_state != MDead) begin
         m_state = MDead;
         m_cpu   = W_stat;
      end else if (m_state == MRun) begin
         if (dbg_halt_req) m_state = MPause;
      end else if (m_state == MPause) begin
         if (!dbg_halt_req) m_state = MRun;
         else if (dbg_step) m_state = MStep;
      end else if (m_state == MStep) begin
         m_state = MPause;
      end
   endtask

   // ---- scenarios ----
   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      #3;
      n_cmp++;
      if (ctl !== 8'b00000111) begin
         n_bad++; $display("FAIL reset_ctl: got %b required %b", ctl, 8'b00000111);
      end
      n_cmp++;
      if (regs !== {2'b00, 4'b1000, 16'h0000}) begin
         n_bad++; $display("FAIL reset_regs: got %h required %h", regs, {2'b00, 4'b1000, 16'h0});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (ctl !== 8'b00000000) begin
         n_bad++; $display("FAIL idle_ctl: got %b required %b", ctl, 8'b0);
      end
      repeat (3) tick();
      W_icode = 4'h6;
      repeat (2) tick();
      n_cmp++;
      if (cnts !== 16'h5200) begin
         n_bad++; $display("FAIL cycle_retired: got %h required %h", cnts, 16'h5200);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
      #1;
      n_cmp++;
      if (ctl !== 8'b11000010) begin
         n_bad++; $display("FAIL lu_mrmov: got %b required %b", ctl, 8'b11000010);
      end
      tick();
      n_cmp++;
      if (cnts !== 16'h1010) begin
         n_bad++; $display("FAIL lu_stall_cnt: got %h required %h", cnts, 16'h1010);
      end
      E_icode = 4'hB; E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'h2;
      #1;
      n_cmp++;
      if (ctl !== 8'b00000000) begin
         n_bad++; $display("FAIL lu_none_dst: got %b required %b", ctl, 8'b0);
      end
      E_dstM = 4'h4; d_srcA = 4'h4;
      #1;
      n_cmp++;
      if (ctl !== 8'b11000010) begin
         n_bad++; $display("FAIL lu_popq_srcA: got %b required %b", ctl, 8'b11000010);
      end
   endtask

   task automatic test_ret();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         D_icode = (i == 0) ? 4'h9 : 4'h1;
         E_icode = (i == 1) ? 4'h9 : 4'h1;
         M_icode = (i == 2) ? 4'h9 : 4'h1;
         #1;
         n_cmp++;
         if (ctl !== 8'b10000100) begin
            n_bad++; $display("FAIL ret_stage%0d: got %b required %b", i, ctl, 8'b10000100);
         end
         tick();
      end
      n_cmp++;
      if (cnts !== 16'h3030) begin
         n_bad++; $display("FAIL ret_stall_cnt: got %h required %h", cnts, 16'h3030);
      end
      // Load/use combined with ret: stall wins on D, no D bubble
      D_icode = 4'h9; M_icode = 4'h1; E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
      #1;
      n_cmp++;
      if (ctl !== 8'b11000010) begin
         n_bad++; $display("FAIL lu_and_ret: got %b required %b", ctl, 8'b11000010);
      end
   endtask

   task automatic test_mispred();
      do_reset();
      E_icode = 4'h7; e_Cnd = 1'b0;
      #1;
      n_cmp++;
      if (ctl !== 8'b00000110) begin
         n_bad++; $display("FAIL mispred_ctl: got %b required %b", ctl, 8'b00000110);
      end
      tick();
      n_cmp++;
      if (cnts !== 16'h1001) begin
         n_bad++; $display("FAIL mispred_cnt: got %h required %h", cnts, 16'h1001);
      end
      e_Cnd = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== 8'b00000000) begin
         n_bad++; $display("FAIL taken_ctl: got %b required %b", ctl, 8'b0);
      end
      tick();
      n_cmp++;
      if (cnts !== 16'h2001) begin
         n_bad++; $display("FAIL taken_cnt: got %h required %h", cnts, 16'h2001);
      end
   endtask

   task automatic test_halt();
      do_reset();
      m_stat = 4'b0010;
      #1;
      n_cmp++;
      if (ctl !== 8'b00000001) begin
         n_bad++; $display("FAIL exc_m_ctl: got %b required %b", ctl, 8'b00000001);
      end
      tick();
      m_stat = 4'b1000;
      n_cmp++;
      if (halted !== 1'b0) begin
         n_bad++; $display("FAIL exc_m_not_dead: got %b required %b", halted, 1'b0);
      end
      tick();
      W_stat = 4'b0100;
      #1;
      n_cmp++;
      if (ctl !== 8'b00001001) begin
         n_bad++; $display("FAIL hlt_ctl: got %b required %b", ctl, 8'b00001001);
      end
      tick();
      n_cmp++;
      if (regs !== {2'b10, 4'b0100, 16'h2000}) begin
         n_bad++; $display("FAIL hlt_enter: got %h required %h", regs, {2'b10, 4'b0100, 16'h2000});
      end
      W_stat = 4'b1000; W_icode = 4'h6; E_icode = 4'h7; e_Cnd = 1'b0; dbg_halt_req = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (regs !== {2'b10, 4'b0100, 16'h2000}) begin
         n_bad++; $display("FAIL dead_hold: got %h required %h", regs, {2'b10, 4'b0100, 16'h2000});
      end
      n_cmp++;
      if (ctl !== 8'b11101001) begin
         n_bad++; $display("FAIL dead_ctl: got %b required %b", ctl, 8'b11101001);
      end
   endtask

   task automatic test_debug();
      do_reset();
      repeat (2) tick();
      dbg_halt_req = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== 8'b00000000) begin
         n_bad++; $display("FAIL req_same_cycle: got %b required %b", ctl, 8'b0);
      end
      tick();
      E_icode = 4'h7; e_Cnd = 1'b0;
      #1;
      n_cmp++;
      if ({paused, ctl} !== 9'b1_11111000) begin
         n_bad++; $display("FAIL pause_ctl: got %b required %b", {paused, ctl}, 9'b1_11111000);
      end
      repeat (3) tick();
      n_cmp++;
      if (cnts !== 16'h3000) begin
         n_bad++; $display("FAIL pause_frozen: got %h required %h", cnts, 16'h3000);
      end
      dbg_step = 1'b1;
      tick();
      dbg_step = 1'b0;
      #1;
      n_cmp++;
      if ({paused, ctl, cnts} !== {1'b0, 8'b00000110, 16'h3000}) begin
         n_bad++; $display("FAIL step_cycle: got %h required %h", {paused, ctl, cnts},
                           {1'b0, 8'b00000110, 16'h3000});
      end
      tick();
      n_cmp++;
      if ({paused, ctl, cnts} !== {1'b1, 8'b11111000, 16'h4001}) begin
         n_bad++; $display("FAIL step_return: got %h required %h", {paused, ctl, cnts},
                           {1'b1, 8'b11111000, 16'h4001});
      end
      dbg_halt_req = 1'b0;
      tick();
      n_cmp++;
      if ({paused, ctl, cnts} !== {1'b0, 8'b00000110, 16'h4001}) begin
         n_bad++; $display("FAIL resume: got %h required %h", {paused, ctl, cnts},
                           {1'b0, 8'b00000110, 16'h4001});
      end
   endtask

   task automatic test_saturate();
      do_reset();
      D_icode = 4'h9; W_icode = 4'h6;
      repeat (20) tick();
      n_cmp++;
      if (cnts !== 16'hFFF0) begin
         n_bad++; $display("FAIL saturate: got %h required %h", cnts, 16'hFFF0);
      end
      dbg_halt_req = 1'b1;
      tick();
      n_cmp++;
      if (paused !== 1'b1) begin
         n_bad++; $display("FAIL sat_pause: got %b required %b", paused, 1'b1);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({regs, ctl} !== {2'b00, 4'b1000, 16'h0000, 8'b00000111}) begin
         n_bad++; $display("FAIL async_reset_pause: got %h required %h", {regs, ctl},
                           {2'b00, 4'b1000, 16'h0000, 8'b00000111});
      end
      @(negedge clk);
      set_idle();
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0]  e_ctl;
      logic [21:0] e_regs;
      do_reset();
      model_reset();
      for (int i = 0; i < 600; i++) begin
         D_icode = 4'($urandom_range(0, 11));
         E_icode = 4'($urandom_range(0, 11));
         M_icode = 4'($urandom_range(0, 11));
         W_icode = 4'($urandom_range(0, 11));
         d_srcA  = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
         d_srcB  = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
         E_dstM  = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
         e_Cnd   = 1'($urandom_range(0, 1));
         m_stat  = ($urandom_range(0, 7) == 0) ? 4'b0001 << $urandom_range(0, 2) : 4'b1000;
         W_stat  = ($urandom_range(0, 40) == 0) ? 4'b0001 << $urandom_range(0, 2) : 4'b1000;
         if ($urandom_range(0, 9) == 0) dbg_halt_req = !dbg_halt_req;
         dbg_step = ($urandom_range(0, 2) == 0);
         #1;
         e_ctl = exp_ctl();
         n_cmp++;
         if (ctl !== e_ctl) begin
            n_bad++; $display("FAIL rand_ctl[%0d]: got %b required %b", i, ctl, e_ctl);
         end
         model_clock();
         tick();
         e_regs = {m_state == MDead, m_state == MPause, m_cpu, m_cyc, m_ret, m_stl, m_mp};
         n_cmp++;
         if (regs !== e_regs) begin
            n_bad++; $display("FAIL rand_regs[%0d]: got %h required %h", i, regs, e_regs);
         end
         if ((m_state == MDead && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0) begin
            do_reset();
            model_reset();
         end
      end
   endtask

   initial begin
      set_idle();
      rst = 1'b0;
      test_reset();
      test_load_use();
      test_ret();
      test_mispred();
      test_halt();
      test_debug();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
